// File: rtl/matrix_pkg.sv
// Types and constants shared between the row assembler and the storage locator.
package matrix_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam int INDEX_WIDTH = 32;

endpackage

// File: rtl/matrix_row_assembler.sv
// Packs a serial element stream into rows of `size` elements and hands each row
// to matrix storage; is_load is meant to drive the locator's is_load directly.
module matrix_row_assembler
  import matrix_pkg::*;
#(
  parameter int size       = 3,
  parameter int data_width = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [data_width-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  output logic [size*data_width-1:0]   out_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         is_load,
  output logic [INDEX_WIDTH-1:0]       col_index,
  output logic                         short_row
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(size - 1);

  state_t                             state_q, state_d;
  logic [INDEX_WIDTH-1:0]             col_index_q, col_index_d;
  logic [size-1:0][data_width-1:0]    row_q, row_d;
  logic                               short_row_q, short_row_d;

  logic            accept;
  logic            row_end;
  logic            early_end;
  logic [size-1:0] slot_we;
  logic [size-1:0] slot_pad;

  // Handshake outputs are gated by reset so nothing leaks out while it is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!reset) begin
      in_ready  = (state_q == FILL);
      out_valid = (state_q == FULL);
    end
  end

  assign is_load   = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign row_end   = accept && (in_last || (col_index_q == LAST_IDX));
  assign early_end = accept && in_last && (col_index_q != LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (row_end) state_d = FULL;
      FULL:    if (is_load) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    col_index_d = col_index_q;
    if (row_end)     col_index_d = '0;
    else if (accept) col_index_d = col_index_q + 1'b1;
  end

  assign short_row_d = short_row_q | early_end;

  // A short row pads every slot above the one being written, so the buffer
  // never needs clearing between rows.
  always_comb begin
    row_d    = row_q;
    slot_we  = '0;
    slot_pad = '0;
    for (int i = 0; i < size; i++) begin
      slot_we[i]  = accept && (col_index_q == INDEX_WIDTH'(i));
      slot_pad[i] = early_end && (col_index_q < INDEX_WIDTH'(i));
      if (slot_we[i])       row_d[i] = in_data;
      else if (slot_pad[i]) row_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      col_index_q <= '0;
      row_q       <= '0;
      short_row_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_index_q <= col_index_d;
      row_q       <= row_d;
      short_row_q <= short_row_d;
    end
  end

  assign out_row   = row_q;
  assign col_index = col_index_q;
  assign short_row = short_row_q;

endmodule

// File: tb/tb_matrix_row_assembler.sv
// Bench for matrix_row_assembler: directed scenarios plus a random run checked
// against a queue-based row model and a small locator model.
module tb_matrix_row_assembler;

  localparam int SIZE = 3;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [DW-1:0]        in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_last = 1'b0;
  logic [SIZE*DW-1:0]   out_row;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 is_load;
  logic [31:0]          col_index;
  logic                 short_row;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_row_assembler #(.size(SIZE), .data_width(DW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .is_load(is_load),
    .col_index(col_index), .short_row(short_row)
  );

  // Reference: elements collect in a queue; a row closes when the queue holds
  // SIZE elements or in_last arrives, then waits for a handshake.
  logic [DW-1:0]      cur[$];
  bit                 m_full;
  bit                 m_short;
  logic [SIZE*DW-1:0] m_row;
  int                 dut_loads = 0;
  int                 lay = 0;
  int                 lrow = 0;

  always @(posedge clk) begin
    if (is_load) dut_loads++;
    if (reset) begin
      cur.delete();
      m_full  = 0;
      m_short = 0;
      m_row   = '0;
      lay     = 0;
      lrow    = 0;
    end else begin
      if (is_load) begin
        lrow++;
        if (lrow == SIZE) begin lrow = 0; lay++; end
      end
      if (m_full) begin
        if (out_ready) m_full = 0;
      end else if (in_valid) begin
        cur.push_back(in_data);
        if (cur.size() == SIZE || in_last) begin
          if (cur.size() < SIZE) m_short = 1;
          m_row = '0;
          foreach (cur[k]) m_row[k*DW +: DW] = cur[k];
          m_full = 1;
          cur.delete();
        end
      end
    end
  end

  task automatic drv(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || is_load !== 1'b0) begin
      bad++;
      $display("FAIL reset_gating: got rdy=%b vld=%b load=%b want 0 0 0", in_ready, out_valid, is_load);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (col_index !== 32'd0 || short_row !== 1'b0 || in_ready !== 1'b1 || out_row !== '0) begin
      bad++;
      $display("FAIL reset_values: got col=%0d short=%b rdy=%b row=%h want 0 0 1 0",
               col_index, short_row, in_ready, out_row);
    end
  endtask

  task automatic test_full_rows();
    logic [SIZE*DW-1:0] exp_row;
    int loads0;
    exp_row = {32'd3, 32'd2, 32'd1};
    loads0  = dut_loads;
    for (int i = 0; i < SIZE; i++) begin
      drv(1'b1, DW'(i + 1), 1'b0, 1'b1);
      total++;
      if (col_index !== 32'(i)) begin
        bad++;
        $display("FAIL full_col_seq: got %0d want %0d", col_index, i);
      end
    end
    drv(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_row !== exp_row || is_load !== 1'b1 || col_index !== 32'd0) begin
      bad++;
      $display("FAIL full_row_out: got vld=%b row=%h load=%b col=%0d want 1 %h 1 0",
               out_valid, out_row, is_load, col_index, exp_row);
    end
    drv(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (is_load !== 1'b0 || in_ready !== 1'b1 || dut_loads - loads0 != 1) begin
      bad++;
      $display("FAIL full_load_pulse: got load=%b rdy=%b pulses=%0d want 0 1 1",
               is_load, in_ready, dut_loads - loads0);
    end
  endtask

  task automatic test_back_pressure();
    logic [SIZE*DW-1:0] exp_row;
    int loads0;
    exp_row = {32'd12, 32'd11, 32'd10};
    loads0  = dut_loads;
    for (int i = 0; i < SIZE; i++) drv(1'b1, DW'(10 + i), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drv(1'b1, 32'hdead_beef, 1'b0, 1'b0);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== exp_row || is_load !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: cyc %0d got rdy=%b vld=%b row=%h load=%b want 0 1 %h 0",
                 c, in_ready, out_valid, out_row, is_load, exp_row);
      end
    end
    drv(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (is_load !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got load=%b want 1", is_load);
    end
    drv(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b1 || dut_loads - loads0 != 1 || col_index !== 32'd0) begin
      bad++;
      $display("FAIL bp_after: got rdy=%b pulses=%0d col=%0d want 1 1 0",
               in_ready, dut_loads - loads0, col_index);
    end
  endtask

  task automatic test_short_row();
    logic [SIZE*DW-1:0] exp_short, exp_full;
    exp_short = {32'd0, 32'd0, 32'd7};
    exp_full  = {32'd3, 32'd2, 32'd1};
    drv(1'b1, 32'd7, 1'b1, 1'b0);
    drv(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_row !== exp_short || short_row !== 1'b1 || col_index !== 32'd0) begin
      bad++;
      $display("FAIL short_row_out: got vld=%b row=%h short=%b col=%0d want 1 %h 1 0",
               out_valid, out_row, short_row, col_index, exp_short);
    end
    for (int i = 0; i < SIZE; i++) drv(1'b1, DW'(i + 1), (i == SIZE - 1), 1'b0);
    drv(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (out_row !== exp_full || short_row !== 1'b1) begin
      bad++;
      $display("FAIL short_sticky: got row=%h short=%b want %h 1", out_row, short_row, exp_full);
    end
  endtask

  task automatic test_gapped();
    logic [SIZE*DW-1:0] exp_row;
    exp_row = {32'd6, 32'd5, 32'd4};
    drv(1'b1, 32'd4, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drv(1'b0, 32'd77, 1'b0, 1'b1);
      total++;
      if (col_index !== 32'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold1: got col=%0d rdy=%b vld=%b want 1 1 0", col_index, in_ready, out_valid);
      end
    end
    drv(1'b1, 32'd5, 1'b0, 1'b1);
    drv(1'b0, 32'd88, 1'b1, 1'b1);
    total++;
    if (col_index !== 32'd2) begin
      bad++;
      $display("FAIL gap_hold2: got col=%0d want 2", col_index);
    end
    drv(1'b1, 32'd6, 1'b0, 1'b1);
    drv(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (out_row !== exp_row || is_load !== 1'b1) begin
      bad++;
      $display("FAIL gap_row: got row=%h load=%b want %h 1", out_row, is_load, exp_row);
    end
  endtask

  task automatic test_reset_mid_row();
    logic [SIZE*DW-1:0] exp_row;
    int loads0;
    exp_row = {32'd3, 32'd2, 32'd1};
    drv(1'b0, '0, 1'b0, 1'b0);
    loads0 = dut_loads;
    drv(1'b1, 32'd8, 1'b0, 1'b1);
    drv(1'b1, 32'd9, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'd10; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (col_index !== 32'd0 || dut_loads != loads0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: got col=%0d pulses=%0d vld=%b want 0 0 0",
               col_index, dut_loads - loads0, out_valid);
    end
    for (int i = 0; i < SIZE; i++) drv(1'b1, DW'(i + 1), 1'b0, 1'b0);
    drv(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (out_row !== exp_row || short_row !== 1'b0) begin
      bad++;
      $display("FAIL midrst_row: got row=%h short=%b want %h 0", out_row, short_row, exp_row);
    end
  endtask

  task automatic test_locator();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < SIZE; i++) drv(1'b1, DW'($urandom), 1'b0, 1'b1);
      drv(1'b0, '0, 1'b0, 1'b1);
      total++;
      if (is_load !== 1'b1 || out_row !== m_row) begin
        bad++;
        $display("FAIL loc_write: row %0d got load=%b data=%h want 1 %h", r, is_load, out_row, m_row);
      end
    end
    drv(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (lay != 2 || lrow != 0) begin
      bad++;
      $display("FAIL loc_end: got layer=%0d row=%0d want 2 0", lay, lrow);
    end
  endtask

  task automatic test_random();
    bit exp_rdy, exp_vld;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = DW'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      exp_rdy = !reset && !m_full;
      exp_vld = !reset && m_full;
      total++;
      if (in_ready !== exp_rdy || out_valid !== exp_vld || is_load !== (exp_vld && out_ready)) begin
        bad++;
        $display("FAIL rand_hs: cyc %0d got rdy=%b vld=%b load=%b want %b %b %b",
                 c, in_ready, out_valid, is_load, exp_rdy, exp_vld, exp_vld && out_ready);
      end
      total++;
      if (col_index !== 32'(cur.size()) || short_row !== m_short) begin
        bad++;
        $display("FAIL rand_state: cyc %0d got col=%0d short=%b want %0d %b",
                 c, col_index, short_row, cur.size(), m_short);
      end
      if (m_full) begin
        total++;
        if (out_row !== m_row) begin
          bad++;
          $display("FAIL rand_row: cyc %0d got %h want %h", c, out_row, m_row);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_rows();
    test_back_pressure();
    test_short_row();
    test_gapped();
    test_reset_mid_row();
    test_locator();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_row_assembler.md
# matrix_row_assembler

Packs a serial stream of matrix elements into full rows of `size` elements and presents each row to matrix storage through a valid/ready handshake. Sits directly upstream of `matrix_storage_locator`: the `is_load` output drives the locator's `is_load` input, so storage writes the row at the locator's current (layer, row) address on the same clock edge that the locator advances. Short rows, flagged by `in_last` before the row is full, are zero-padded and reported.

## Interface
Parameters:
- `size`, default 3: elements per row; must match the locator's `size`; must be at least 2.
- `data_width`, default 32: bits per element.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  `data_width`: element value.
- `in_valid`  in  1: `in_data` and `in_last` are valid.
- `in_ready`  out  1: block accepts an element this cycle.
- `in_last`  in  1: marks the final element of the current row, or of the stream segment.
- `out_row`  out  `size*data_width`: assembled row; element 0 occupies bits `[data_width-1:0]`.
- `out_valid`  out  1: `out_row` holds a complete row.
- `out_ready`  in  1: storage accepts the row.
- `is_load`  out  1: equals `out_valid && out_ready`; connects to the locator.
- `col_index`  out  32: next element slot to be filled (0..size-1).
- `short_row`  out  1: sticky flag; a row was terminated early by `in_last`.

## Operation
- There are two states, defined by `state_t` = {FILL, FULL}.
- **FILL state**
  - `in_ready` = 1 and `out_valid` = 0.
  - An element is accepted when `in_valid && in_ready`. It is written to slot `col_index`.
  - After a normal accept, `col_index` increments.
  - If the element is accepted with `col_index == size-1`, the block moves to FULL and `col_index` returns to 0.
  - If the element is accepted with `in_last` = 1 and `col_index < size-1`:
    - slots `col_index+1..size-1` are cleared to 0 on the same edge;
    - `short_row` is set;
    - the block moves to FULL and `col_index` returns to 0.
  - `in_last` on the slot `size-1` element is a normal row end and does not set `short_row`.
- **FULL state**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_row` stays stable until the handshake completes.
  - When `out_ready` = 1, `is_load` = 1 in that cycle and the next state is FILL.
- The row buffer is not cleared between rows. Every slot is overwritten, either by data or by padding, before the next FULL.
- `short_row` is cleared only by reset.
- `col_index` wraps from `size-1` to 0 and never exceeds `size-1`.

## Timing
- **Reset values** (on the edge where `reset` = 1):
  - state FILL, `col_index` 0, row buffer 0, `short_row` 0.
  - While `reset` is high, `in_ready`, `out_valid` and `is_load` are forced to 0 combinationally.
- **Latency**: the last element is accepted at edge N, and `out_valid` = 1 from the cycle after edge N.
- **Throughput**: `size` + 1 cycles per row at best, i.e. `size` accept cycles plus 1 handshake cycle. No element is accepted in FULL.
- `is_load` is combinational from `out_ready`. The locator and storage both sample on the same edge, with no extra register.
- `in_valid` may drop in FILL without loss. The partial row and `col_index` are held.
- `out_ready` held high in FILL has no effect.
- **Reset mid-row or during FULL**: the partial or pending row is discarded, with no `is_load` pulse, and the block returns to its reset values.
- The `in_data` value during `in_ready` = 0 is ignored.

## Structure
- Shared package `matrix_pkg`:
  - `state_t` enum {FILL, FULL};
  - localparam `INDEX_WIDTH` = 32, also used by the locator's index ports.
- A single module with no sub-module. The row buffer is an array of `size` registers with a per-slot write enable, decoded from `col_index`, accept and pad.

## Test plan
- **Full rows, size=3**: stream 1,2,3 continuously with `out_ready` = 1.
  - `out_row` = {3,2,1} with `out_valid` on the cycle after 3 is accepted.
  - `is_load` pulses for 1 cycle and `col_index` sequence is 0,1,2,0.
- **Back-pressure**: after a row completes, hold `out_ready` = 0 for 5 cycles.
  - `in_ready` = 0 and `out_row` is stable throughout.
  - Raising `out_ready` gives exactly one `is_load` pulse, then `in_ready` = 1.
- **Short row**: send 7 with `in_last` = 1 at `col_index` 0.
  - `out_row` = {0,0,7} and `short_row` = 1, held across subsequent full rows.
- **Gapped input**: send 4, idle 3 cycles, send 5, idle, send 6.
  - `out_row` = {6,5,4}; `col_index` holds during the gaps.
- **Reset mid-row**: accept 8 and 9, then assert `reset` for 1 cycle.
  - No `is_load` occurs and `col_index` = 0.
  - The next row 1,2,3 yields {3,2,1}.
- **Locator integration**: with `matrix_storage_locator` connected, send 6 rows.
  - Locator ends at layer 2, row 0.
  - `is_load` coincides with each storage write.
